// File: rtl/wfg_sequencer_if.sv
// Host/table side and WFG control side of the segment sequencer.
// The sequencer is the slave; the host or bench is the master.
interface wfg_sequencer_if #(
  parameter int AW      = 3,
  parameter int DWELL_W = 16
);
  localparam int DW = 19 + DWELL_W;

  logic          start;
  logic          stop;
  logic          loop;
  logic [AW-1:0] last_idx;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW-1:0] prog_data;

  logic [10:0]   wfg_sel;
  logic [7:0]    wfg_phase;
  logic          wfg_rst;
  logic          wfg_preset;
  logic          wfg_ld;
  logic          busy;
  logic          done;
  logic [AW-1:0] cur_idx;

  modport master (
    output start, stop, loop, last_idx,
    output prog_we, prog_addr, prog_data,
    input  wfg_sel, wfg_phase, wfg_rst,
    input  wfg_preset, wfg_ld, busy, done, cur_idx
  );

  modport slave (
    input  start, stop, loop, last_idx,
    input  prog_we, prog_addr, prog_data,
    output wfg_sel, wfg_phase, wfg_rst,
    output wfg_preset, wfg_ld, busy, done, cur_idx
  );
endinterface

// File: rtl/wfg_sequencer.sv
// Segment sequencer for the DDS waveform generator.
// Plays a table of {sel, phase, dwell} entries as reset/run segments.
module wfg_sequencer #(
  parameter int DEPTH     = 8,
  parameter int AW        = 3,
  parameter int DWELL_W   = 16,
  parameter int SETUP_CYC = 4
) (
  input  logic           clk,
  input  logic           rst,
  wfg_sequencer_if.slave bus
);
  localparam int DW = 19 + DWELL_W;
  localparam logic [DWELL_W-1:0] SETUP_LD =
    DWELL_W'(SETUP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE, SETUP, RUN, FINISH
  } state_t;

  state_t               state, state_n;
  logic [AW-1:0]        idx, idx_n;
  logic [DWELL_W-1:0]   cnt, cnt_n;
  logic [AW-1:0]        last_q;
  logic                 loop_q;
  logic                 capture;

  logic [DW-1:0]        tbl [DEPTH];
  logic [DW-1:0]        ent;
  logic [DWELL_W-1:0]   dwell;
  logic [DWELL_W-1:0]   run_ld;

  logic [10:0]          sel_q;
  logic [7:0]           phase_q;
  logic                 rst_q, preset_q, ld_q;
  logic                 busy_q, done_q;
  logic [AW-1:0]        cur_q;

  assign ent    = tbl[idx];
  assign dwell  = ent[DWELL_W-1:0];
  // dwell of zero still runs one cycle
  assign run_ld = (dwell == '0) ? '0 : dwell - 1'b1;

  // table writes accepted only while no playback is active
  always_ff @(posedge clk) begin
    if (bus.prog_we && !busy_q)
      tbl[bus.prog_addr] <= bus.prog_data;
  end

  // next-state, index and cycle counter
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    capture = 1'b0;
    if (bus.stop) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state_n = SETUP;
            idx_n   = '0;
            cnt_n   = SETUP_LD;
            capture = 1'b1;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state_n = RUN;
            cnt_n   = run_ld;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
        RUN: begin
          if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
          end else if (idx != last_q) begin
            state_n = SETUP;
            idx_n   = idx + 1'b1;
            cnt_n   = SETUP_LD;
          end else if (loop_q) begin
            state_n = SETUP;
            idx_n   = '0;
            cnt_n   = SETUP_LD;
          end else begin
            state_n = FINISH;
          end
        end
        FINISH: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // state registers and registered generator controls
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      last_q   <= '0;
      loop_q   <= 1'b0;
      sel_q    <= '0;
      phase_q  <= '0;
      rst_q    <= 1'b1;
      preset_q <= 1'b0;
      ld_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cur_q    <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      if (capture) begin
        last_q <= bus.last_idx;
        loop_q <= bus.loop;
      end
      if (state_n == SETUP && state != SETUP) begin
        sel_q   <= tbl[idx_n][DW-1 -: 11];
        phase_q <= tbl[idx_n][DWELL_W +: 8];
        cur_q   <= idx_n;
      end
      rst_q    <= (state_n != RUN);
      preset_q <= (state_n == RUN);
      ld_q     <= (state_n == RUN) && (state == SETUP);
      busy_q   <= (state_n == SETUP) || (state_n == RUN);
      done_q   <= (state_n == FINISH);
    end
  end

  assign bus.wfg_sel    = sel_q;
  assign bus.wfg_phase  = phase_q;
  assign bus.wfg_rst    = rst_q;
  assign bus.wfg_preset = preset_q;
  assign bus.wfg_ld     = ld_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cur_idx    = cur_q;
endmodule

// File: tb/tb_wfg_sequencer.sv
// Bench for wfg_sequencer: per-cycle output trace vs a
// schedule expanded from the table contents.
module tb_wfg_sequencer;
  localparam int AW      = 3;
  localparam int DWELL_W = 16;
  localparam int SC      = 4;
  localparam int DEPTH   = 8;

  typedef logic [26:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   passed = 0;
  int   total  = 0;

  logic [34:0] mtab [DEPTH];
  vec_t        exp_q [$];
  vec_t        idle_v;

  wfg_sequencer_if #(.AW(AW), .DWELL_W(DWELL_W)) intf ();

  wfg_sequencer #(
    .DEPTH(DEPTH), .AW(AW),
    .DWELL_W(DWELL_W), .SETUP_CYC(SC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(intf)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(
    logic [10:0] s, logic [7:0] p,
    logic r, logic pr, logic l,
    logic b, logic d, logic [2:0] c);
    return {s, p, r, pr, l, b, d, c};
  endfunction

  function automatic vec_t obs();
    return {intf.wfg_sel, intf.wfg_phase,
            intf.wfg_rst, intf.wfg_preset,
            intf.wfg_ld, intf.busy,
            intf.done, intf.cur_idx};
  endfunction

  // Expand table into cycle-by-cycle expected outputs,
  // starting with the cycle after the start edge.
  function automatic void build(int last, bit lp, int maxc);
    int i;
    int d;
    logic [10:0] s;
    logic [7:0]  p;
    i = 0;
    exp_q.delete();
    while (exp_q.size() < maxc) begin
      s = mtab[i][34:24];
      p = mtab[i][23:16];
      d = int'(mtab[i][15:0]);
      if (d == 0) d = 1;
      repeat (SC)
        exp_q.push_back(mk(s, p, 1'b1, 1'b0, 1'b0,
                           1'b1, 1'b0, 3'(i)));
      for (int k = 0; k < d; k++)
        exp_q.push_back(mk(s, p, 1'b0, 1'b1, k == 0,
                           1'b1, 1'b0, 3'(i)));
      if (i == last) begin
        if (!lp) begin
          exp_q.push_back(mk(s, p, 1'b1, 1'b0, 1'b0,
                             1'b0, 1'b1, 3'(i)));
          idle_v = mk(s, p, 1'b1, 1'b0, 1'b0,
                      1'b0, 1'b0, 3'(i));
          exp_q.push_back(idle_v);
          break;
        end
        i = 0;
      end else begin
        i = (i + 1) % DEPTH;
      end
    end
  endfunction

  task automatic prog(input int a, input logic [34:0] d);
    @(negedge clk);
    intf.prog_we   = 1'b1;
    intf.prog_addr = 3'(a);
    intf.prog_data = d;
    @(negedge clk);
    intf.prog_we = 1'b0;
    mtab[a] = d;
  endtask

  task automatic kick(input int last, input bit lp);
    @(negedge clk);
    intf.start    = 1'b1;
    intf.last_idx = 3'(last);
    intf.loop     = lp;
  endtask

  function automatic logic [34:0] rnd_ent(int dmax);
    return {11'($urandom), 8'($urandom),
            16'($urandom_range(0, dmax))};
  endfunction

  task automatic test_reset();
    vec_t rv;
    rv = mk('0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (obs() !== rv)
      $display("FAIL reset_hold got %h want %h", obs(), rv);
    else passed++;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (obs() !== rv)
      $display("FAIL reset_idle got %h want %h", obs(), rv);
    else passed++;
  endtask

  task automatic test_single();
    prog(0, {11'b01111111101, 8'd1, 16'd10});
    build(0, 1'b0, 1000);
    kick(0, 1'b0);
    foreach (exp_q[k]) begin
      @(negedge clk);
      if (k == 0) intf.start = 1'b0;
      total++;
      if (obs() !== exp_q[k])
        $display("FAIL single cyc%0d got %h want %h",
                 k, obs(), exp_q[k]);
      else passed++;
    end
  endtask

  task automatic test_three();
    int nld;
    int nbusy;
    nld = 0;
    nbusy = 0;
    prog(0, {11'($urandom), 8'($urandom), 16'd5});
    prog(1, {11'($urandom), 8'($urandom), 16'd0});
    prog(2, {11'($urandom), 8'($urandom), 16'd7});
    build(2, 1'b0, 1000);
    kick(2, 1'b0);
    foreach (exp_q[k]) begin
      @(negedge clk);
      if (k == 0) intf.start = 1'b0;
      if (intf.wfg_ld === 1'b1) nld++;
      if (intf.busy === 1'b1) nbusy++;
      total++;
      if (obs() !== exp_q[k])
        $display("FAIL three cyc%0d got %h want %h",
                 k, obs(), exp_q[k]);
      else passed++;
    end
    total++;
    if (nld !== 3)
      $display("FAIL three_ld got %0d want 3", nld);
    else passed++;
    total++;
    if (nbusy !== 25)
      $display("FAIL three_busy got %0d want 25", nbusy);
    else passed++;
  endtask

  task automatic test_random();
    int last;
    for (int r = 0; r < 3; r++) begin
      for (int a = 0; a < DEPTH; a++) prog(a, rnd_ent(8));
      last = $urandom_range(0, DEPTH - 1);
      build(last, 1'b0, 2000);
      kick(last, 1'b0);
      foreach (exp_q[k]) begin
        @(negedge clk);
        if (k == 0) begin
          intf.start    = 1'b0;
          intf.last_idx = 3'($urandom);
          intf.loop     = 1'($urandom);
        end
        total++;
        if (obs() !== exp_q[k])
          $display("FAIL random r%0d cyc%0d got %h want %h",
                   r, k, obs(), exp_q[k]);
        else passed++;
      end
      intf.loop = 1'b0;
    end
  endtask

  task automatic test_loop_stop();
    int   n;
    vec_t e;
    vec_t sv;
    prog(0, rnd_ent(6));
    prog(1, rnd_ent(6));
    build(1, 1'b1, 80);
    n = $urandom_range(25, 45);
    while (!exp_q[n][6]) n++;
    kick(1, 1'b1);
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (k == 0) intf.start = 1'b0;
      total++;
      if (obs() !== exp_q[k])
        $display("FAIL loop cyc%0d got %h want %h",
                 k, obs(), exp_q[k]);
      else passed++;
    end
    intf.stop = 1'b1;
    e = exp_q[n];
    sv = mk(e[26:16], e[15:8], 1'b1, 1'b0, 1'b0,
            1'b0, 1'b0, e[2:0]);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      intf.stop = 1'b0;
      total++;
      if (obs() !== sv)
        $display("FAIL stop cyc%0d got %h want %h",
                 k, obs(), sv);
      else passed++;
    end
    idle_v = sv;
    intf.loop = 1'b0;
  endtask

  task automatic test_start_stop();
    @(negedge clk);
    intf.start = 1'b1;
    intf.stop  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      intf.start = 1'b0;
      intf.stop  = 1'b0;
      total++;
      if (obs() !== idle_v)
        $display("FAIL start_stop cyc%0d got %h want %h",
                 k, obs(), idle_v);
      else passed++;
    end
  endtask

  task automatic test_lockout();
    logic [34:0] nw;
    for (int a = 0; a < 3; a++) prog(a, rnd_ent(5));
    nw = mtab[1] ^ {11'h7FF, 8'hFF, 16'h0};
    build(2, 1'b0, 1000);
    kick(2, 1'b0);
    foreach (exp_q[k]) begin
      @(negedge clk);
      if (k == 0) intf.start = 1'b0;
      total++;
      if (obs() !== exp_q[k])
        $display("FAIL lock1 cyc%0d got %h want %h",
                 k, obs(), exp_q[k]);
      else passed++;
      intf.prog_we = 1'b0;
      if (k == 5) begin
        intf.prog_we   = 1'b1;
        intf.prog_addr = 3'd1;
        intf.prog_data = nw;
        if (!exp_q[k][4]) mtab[1] = nw;
      end
    end
    intf.prog_we = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) prog(1, nw);
      build(2, 1'b0, 1000);
      kick(2, 1'b0);
      foreach (exp_q[k]) begin
        @(negedge clk);
        if (k == 0) intf.start = 1'b0;
        total++;
        if (obs() !== exp_q[k])
          $display("FAIL lock_play%0d cyc%0d got %h want %h",
                   pass, k, obs(), exp_q[k]);
        else passed++;
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int   n;
    vec_t rv;
    rv = mk('0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    build(2, 1'b0, 1000);
    n = 0;
    while (!(exp_q[n][6] && exp_q[n][2:0] == 3'd2)) n++;
    kick(2, 1'b0);
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      if (k == 0) intf.start = 1'b0;
      total++;
      if (obs() !== exp_q[k])
        $display("FAIL rmid cyc%0d got %h want %h",
                 k, obs(), exp_q[k]);
      else passed++;
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rst = 1'b1;
      total++;
      if (obs() !== rv)
        $display("FAIL rmid_reset cyc%0d got %h want %h",
                 k, obs(), rv);
      else passed++;
    end
  endtask

  initial begin
    intf.start     = 1'b0;
    intf.stop      = 1'b0;
    intf.loop      = 1'b0;
    intf.last_idx  = '0;
    intf.prog_we   = 1'b0;
    intf.prog_addr = '0;
    intf.prog_data = '0;
    test_reset();
    test_single();
    test_three();
    test_random();
    test_loop_stop();
    test_start_stop();
    test_lockout();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
